// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode enum, width, arbiter state and result bundle.
// Imported by alu_core and alu_arbiter.
package alu_pkg;

  localparam int ALU_W = 32;

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_ADD = 3'b010,
    OP_XOR = 3'b011,
    OP_NOR = 3'b100,
    OP_SRL = 3'b101,
    OP_SUB = 3'b110,
    OP_SLT = 3'b111
  } alu_op_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic [ALU_W-1:0] r;
    logic             id;
    logic             zero;
    logic             ovf;
  } res_t;

endpackage

// File: rtl/alu_core.sv
// Combinational 32-bit ALU. Ports: a, b operands; op opcode;
// r result; zero (r==0); ovf signed overflow for ADD/SUB only.
module alu_core
  import alu_pkg::*;
(
  input  logic [ALU_W-1:0] a,
  input  logic [ALU_W-1:0] b,
  input  alu_op_t          op,
  output logic [ALU_W-1:0] r,
  output logic             zero,
  output logic             ovf
);

  logic [ALU_W-1:0] sum;
  logic [ALU_W-1:0] diff;
  logic             lt;

  assign sum  = a + b;
  assign diff = a - b;
  assign lt   = $signed(a) < $signed(b);

  always_comb begin
    r   = '0;
    ovf = 1'b0;
    unique case (op)
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      OP_XOR: r = a ^ b;
      OP_NOR: r = ~(a | b);
      OP_SRL: r = a >> b[4:0];
      OP_SLT: r = {{(ALU_W-1){1'b0}}, lt};
      OP_ADD: begin
        r   = sum;
        ovf = (a[ALU_W-1] == b[ALU_W-1]) &&
              (sum[ALU_W-1] != a[ALU_W-1]);
      end
      OP_SUB: begin
        r   = diff;
        ovf = (a[ALU_W-1] != b[ALU_W-1]) &&
              (diff[ALU_W-1] != a[ALU_W-1]);
      end
    endcase
  end

  assign zero = (r == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin two-requester front end for one alu_core with a registered,
// tagged valid/ready result. Ports: clk, rst_n (async low); req_valid/
// req_ready, a0/b0/op0, a1/b1/op1 requests; res_valid/res_ready, res,
// res_id, res_zero, res_ovf result. Optional grant_cnt0/grant_cnt1
// saturating grant counters when ALU_ARB_STATS_EN is defined.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [1:0]   req_valid,
  output logic [1:0]   req_ready,
  input  logic [W-1:0] a0,
  input  logic [W-1:0] b0,
  input  logic [2:0]   op0,
  input  logic [W-1:0] a1,
  input  logic [W-1:0] b1,
  input  logic [2:0]   op1,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [W-1:0] res,
  output logic         res_id,
  output logic         res_zero,
  output logic         res_ovf
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [15:0]  grant_cnt0,
  output logic [15:0]  grant_cnt1
`endif
);

  arb_state_t state_q, state_d;
  res_t       res_q;
  logic       last_q;
  logic       cand;
  logic       can_accept;
  logic       grant;

  logic [W-1:0] alu_a, alu_b, alu_r;
  alu_op_t      alu_op;
  logic         alu_zero, alu_ovf;

  // Contention goes to whoever was not granted last.
  always_comb begin
    unique case (req_valid)
      2'b10:   cand = 1'b1;
      2'b11:   cand = ~last_q;
      default: cand = 1'b0;
    endcase
  end

  // rst_n gates accept so no handshake completes while held in reset.
  assign can_accept = rst_n &&
                      ((state_q == ST_EMPTY) || res_ready);
  assign grant      = can_accept && req_valid[cand];
  assign req_ready  = !grant ? 2'b00 :
                      (cand ? 2'b10 : 2'b01);

  assign alu_a  = cand ? a1 : a0;
  assign alu_b  = cand ? b1 : b0;
  assign alu_op = alu_op_t'(cand ? op1 : op0);

  alu_core u_core (
    .a    (alu_a),
    .b    (alu_b),
    .op   (alu_op),
    .r    (alu_r),
    .zero (alu_zero),
    .ovf  (alu_ovf)
  );

  always_comb begin
    state_d = state_q;
    if (grant)
      state_d = ST_FULL;
    else if (state_q == ST_FULL && res_ready)
      state_d = ST_EMPTY;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      res_q   <= '0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      if (grant) begin
        res_q  <= '{r: alu_r, id: cand,
                    zero: alu_zero, ovf: alu_ovf};
        last_q <= cand;
      end
    end
  end

  assign res_valid = (state_q == ST_FULL);
  assign res       = res_q.r;
  assign res_id    = res_q.id;
  assign res_zero  = res_q.zero;
  assign res_ovf   = res_q.ovf;

`ifdef ALU_ARB_STATS_EN
  logic [15:0] cnt0_q, cnt1_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else if (grant) begin
      if (!cand && cnt0_q != 16'hFFFF)
        cnt0_q <= cnt0_q + 16'd1;
      if (cand && cnt1_q != 16'hFFFF)
        cnt1_q <= cnt1_q + 16'd1;
    end
  end

  assign grant_cnt0 = cnt0_q;
  assign grant_cnt1 = cnt1_q;
`endif

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-requester front end for the shared 32-bit ALU. It grants one requester per cycle by round-robin and executes the operation on a single `alu_core` instance. It registers the result with a tag and presents it on a valid/ready output that supports back-to-back throughput. It sits between the issue logic of two clients and the single ALU datapath.

## Interface
Parameters:
- `W`, 32: operand/result width. Only 32 is supported.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  2  per-requester request valid; bit i = requester i.
- `req_ready`  out  2  per-requester accept; at most one bit high per cycle.
- `a0`, `b0`  in  32 each  requester 0 operands.
- `op0`  in  3  requester 0 opcode.
- `a1`, `b1`  in  32 each  requester 1 operands.
- `op1`  in  3  requester 1 opcode.
- `res_valid`  out  1  result valid.
- `res_ready`  in  1  consumer accepts result.
- `res`  out  32  result.
- `res_id`  out  1  index of the requester that issued the result.
- `res_zero`  out  1  `res == 0`.
- `res_ovf`  out  1  signed overflow; ADD/SUB only, otherwise 0.
- `grant_cnt0`, `grant_cnt1`  out  16 each  present only with `ALU_ARB_STATS_EN`.

## Operation
- Opcodes:
  - 000 AND.
  - 001 OR.
  - 010 ADD.
  - 011 XOR.
  - 100 NOR, `~(a|b)`.
  - 101 SRL, `a >> b[4:0]`.
  - 110 SUB, `a-b`.
  - 111 SLT, signed; result 32'd1 or 32'd0.
- Arithmetic: ADD/SUB wrap modulo 2^32.
  - ADD: `ovf = (a[31]==b[31]) && (r[31]!=a[31])`.
  - SUB: `ovf = (a[31]!=b[31]) && (r[31]!=a[31])`.
- States:
  - EMPTY: no result held.
  - FULL: result held, `res_valid=1`.
- Accept condition: `can_accept = (state==EMPTY) || res_ready`.
- Grant:
  - If only one `req_valid` bit is set, that requester is the candidate.
  - If both are set, the candidate is the requester not granted last (`last` register).
  - `req_ready[cand] = can_accept && req_valid[cand]`. It is combinational and never depends on `req_ready` itself.
- Handshake on requester i (`req_valid[i] && req_ready[i]`):
  - `alu_core` computes combinationally on requester i's operands.
  - `res`, `res_id`, `res_zero` and `res_ovf` are registered.
  - Next state is FULL.
  - `last <= i`.
- Output handshake: `res_valid && res_ready` with no new grant in the same cycle gives next state EMPTY.
- Simultaneous output handshake and new grant: FULL→FULL with the new result. No bubble.
- Requesters hold `valid` and operands stable until accepted. Dropping `valid` early is legal; the request is then simply not taken.
- `res`, `res_id`, `res_zero` and `res_ovf` stay stable while `res_valid && !res_ready`.

## Timing
- Latency: a request accepted at edge N has its result visible with `res_valid=1` after edge N.
- Throughput: 1 op/cycle while `res_ready` is held high.
- Reset values:
  - `res_valid=0`, `res=0`, `res_id=0`, `res_zero=0`, `res_ovf=0`.
  - `last=1`, so requester 0 wins the first contention.
  - Counters = 0.
- Reset asserted mid-operation: the held result is discarded immediately (asynchronous) and no grant is issued while `rst_n=0`.
- `req_ready` is 0 in FULL when `res_ready=0`, regardless of `req_valid`.

## Configuration
- `ALU_ARB_STATS_EN` defined:
  - `grant_cnt0` and `grant_cnt1` exist.
  - Each counts accepted requests for its requester.
  - 16-bit, saturating at 16'hFFFF. Reset 0.
- Not defined: the counter ports and registers are absent. All other behaviour is identical.

## Structure
- Package `alu_pkg`:
  - Opcode constants/enum `alu_op_t` (3-bit).
  - `ALU_W = 32`.
- Sub-module `alu_core`: purely combinational.
  - Inputs: `a`, `b`, `op`.
  - Outputs: `r`, `zero`, `ovf`.
- `alu_arbiter` holds only the arbitration, the state register and the output register.

## Test plan
- Single request: `req_valid=01`, `a0=32'h0000_00F0`, `b0=32'h0000_000F`, `op0=NOR`.
  - `req_ready=01`.
  - Next cycle: `res=32'hFFFF_FF00`, `res_id=0`, `res_zero=0`.
- Contention: both valid continuously, `res_ready=1`. Grants alternate 0,1,0,1 starting with 0, one result per cycle.
- Backpressure: result held with `res_ready=0` for 3 cycles while both requesters are valid.
  - `req_ready=00` throughout.
  - `res` stays unchanged.
  - On `res_ready=1`, the held result retires and a new grant issues in the same cycle.
- Overflow:
  - ADD `7FFF_FFFF + 1` → `res=8000_0000`, `res_ovf=1`.
  - SUB `0 - 0` → `res_zero=1`, `res_ovf=0`.
  - SLT `FFFF_FFFF` vs `1` → `res=1`.
- Reset while FULL: `rst_n` low mid-cycle → `res_valid` drops to 0 immediately. After release, requester 0 wins the first contention.
- With `ALU_ARB_STATS_EN`: 5 grants to requester 0 and 3 to requester 1 → `grant_cnt0=5`, `grant_cnt1=3`. A counter forced to `FFFF` stays at `FFFF` on a further grant.
